// File: rtl/ex_muldiv.sv
// EX-stage multiply / multiply-accumulate / divide unit with HI/LO write request and pipeline stall.
// Op encodings are kept in ex_muldiv_pkg so the pipeline and its benches share one definition.
package ex_muldiv_pkg;
  localparam int unsigned ALUOP_W = 8;
  typedef logic [ALUOP_W-1:0] aluop_t;

  localparam aluop_t EXE_NOP_OP   = 8'b0000_0000;
  localparam aluop_t EXE_MULT_OP  = 8'b0001_1000;
  localparam aluop_t EXE_MULTU_OP = 8'b0001_1001;
  localparam aluop_t EXE_DIV_OP   = 8'b0001_1010;
  localparam aluop_t EXE_DIVU_OP  = 8'b0001_1011;
  localparam aluop_t EXE_MADD_OP  = 8'b1010_0110;
  localparam aluop_t EXE_MADDU_OP = 8'b1010_1000;
  localparam aluop_t EXE_MSUB_OP  = 8'b1010_1010;
  localparam aluop_t EXE_MSUBU_OP = 8'b1010_1011;
endpackage

module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  aluop_t           aluop_i,
  input  logic [WIDTH-1:0] reg1_i,
  input  logic [WIDTH-1:0] reg2_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             annul_i,
  output logic             whilo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             stallreq_o
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t           state;
  logic             ph;
  logic [DW-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic             neg_quo;
  logic             neg_rem;
  logic [CNT_W-1:0] cnt;

  // Op decode
  logic is_mul, is_macc, is_sub, is_signed, is_div;
  always_comb begin
    is_mul    = 1'b0;
    is_macc   = 1'b0;
    is_sub    = 1'b0;
    is_signed = 1'b0;
    is_div    = 1'b0;
    unique case (aluop_i)
      EXE_MULT_OP:  begin is_mul  = 1'b1; is_signed = 1'b1; end
      EXE_MULTU_OP: begin is_mul  = 1'b1; end
      EXE_MADD_OP:  begin is_macc = 1'b1; is_signed = 1'b1; end
      EXE_MADDU_OP: begin is_macc = 1'b1; end
      EXE_MSUB_OP:  begin is_macc = 1'b1; is_sub = 1'b1; is_signed = 1'b1; end
      EXE_MSUBU_OP: begin is_macc = 1'b1; is_sub = 1'b1; end
      EXE_DIV_OP:   begin is_div  = 1'b1; is_signed = 1'b1; end
      EXE_DIVU_OP:  begin is_div  = 1'b1; end
      default: ;
    endcase
  end

  // Operands are extended to full product width so one truncated multiply serves signed and unsigned
  logic [DW-1:0] mul_a, mul_b, product, acc_res;
  assign mul_a   = is_signed ? {{WIDTH{reg1_i[WIDTH-1]}}, reg1_i} : {{WIDTH{1'b0}}, reg1_i};
  assign mul_b   = is_signed ? {{WIDTH{reg2_i[WIDTH-1]}}, reg2_i} : {{WIDTH{1'b0}}, reg2_i};
  assign product = mul_a * mul_b;
  assign acc_res = is_sub ? ({hi_i, lo_i} - prod) : ({hi_i, lo_i} + prod);

  logic             neg1, neg2;
  logic [WIDTH-1:0] abs1, abs2;
  assign neg1 = is_signed & reg1_i[WIDTH-1];
  assign neg2 = is_signed & reg2_i[WIDTH-1];
  assign abs1 = neg1 ? (~reg1_i + WIDTH'(1)) : reg1_i;
  assign abs2 = neg2 ? (~reg2_i + WIDTH'(1)) : reg2_i;

  // Restoring step: quo holds the unshifted dividend bits in its MSBs, quotient bits enter at the LSB
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign trial   = {rem, quo[WIDTH-1]} - {1'b0, dsr};
  assign quo_fix = neg_quo ? (~quo + WIDTH'(1)) : quo;
  assign rem_fix = neg_rem ? (~rem + WIDTH'(1)) : rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ph      <= 1'b0;
      prod    <= '0;
      quo     <= '0;
      rem     <= '0;
      dsr     <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      cnt     <= '0;
    end else if (annul_i) begin
      state <= S_IDLE;
      ph    <= 1'b0;
    end else begin
      ph <= 1'b0;
      if (state == S_IDLE && is_macc && !ph) begin
        ph   <= 1'b1;
        prod <= product;
      end
      unique case (state)
        S_IDLE: begin
          if (is_div) begin
            cnt     <= '0;
            neg_quo <= neg1 ^ neg2;
            neg_rem <= neg1;
            rem     <= '0;
            quo     <= abs1;
            dsr     <= abs2;
            state   <= (reg2_i == '0) ? S_DIVZERO : S_ON;
          end
        end
        S_DIVZERO: begin
          quo     <= '0;
          rem     <= '0;
          neg_quo <= 1'b0;
          neg_rem <= 1'b0;
          state   <= S_END;
        end
        S_ON: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_END;
        end
        S_END:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are a same-cycle decode, forced quiet during reset and flush
  always_comb begin
    whilo_o    = 1'b0;
    stallreq_o = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    if (rst && !annul_i) begin
      unique case (state)
        S_END: begin
          whilo_o = 1'b1;
          hi_o    = rem_fix;
          lo_o    = quo_fix;
        end
        S_DIVZERO, S_ON: stallreq_o = 1'b1;
        default: begin
          if (is_mul) begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = product;
          end else if (is_macc) begin
            if (ph) begin
              whilo_o      = 1'b1;
              {hi_o, lo_o} = acc_res;
            end else begin
              stallreq_o = 1'b1;
            end
          end else if (is_div) begin
            stallreq_o = 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised self-checking bench for ex_muldiv against a plain-arithmetic reference model.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  aluop_t      aluop = EXE_NOP_OP;
  logic [31:0] reg1 = '0, reg2 = '0, hi_in = '0, lo_in = '0;
  logic        annul = 1'b0;
  logic        whilo, stallreq;
  logic [31:0] hi_out, lo_out;
  int          checks = 0;
  int          errors = 0;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .reg1_i(reg1), .reg2_i(reg2),
    .hi_i(hi_in), .lo_i(lo_in), .annul_i(annul),
    .whilo_o(whilo), .hi_o(hi_out), .lo_o(lo_out), .stallreq_o(stallreq)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  function automatic bit op_signed(input aluop_t op);
    return op == EXE_MULT_OP || op == EXE_MADD_OP || op == EXE_MSUB_OP || op == EXE_DIV_OP;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input aluop_t op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    aluop = op; reg1 = a; reg2 = b;
    exp = model_mul(a, b, op_signed(op));
    @(negedge clk);
    checks++;
    if (whilo !== 1'b1 || stallreq !== 1'b0 || {hi_out, lo_out} !== exp) begin
      errors++;
      $display("FAIL mul op=%h a=%h b=%h: got we=%b st=%b %h_%h, exp we=1 st=0 %h", op, a, b,
               whilo, stallreq, hi_out, lo_out, exp);
    end
    step();
  endtask

  task automatic run_madd(input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l);
    logic [63:0] p, exp;
    aluop = op; reg1 = a; reg2 = b; hi_in = h; lo_in = l;
    p   = model_mul(a, b, op_signed(op));
    exp = (op == EXE_MSUB_OP || op == EXE_MSUBU_OP) ? ({h, l} - p) : ({h, l} + p);
    @(negedge clk);
    checks++;
    if (whilo !== 1'b0 || stallreq !== 1'b1) begin
      errors++;
      $display("FAIL madd_c1 op=%h: got we=%b st=%b, exp we=0 st=1", op, whilo, stallreq);
    end
    step();
    @(negedge clk);
    checks++;
    if (whilo !== 1'b1 || stallreq !== 1'b0 || {hi_out, lo_out} !== exp) begin
      errors++;
      $display("FAIL madd_c2 op=%h a=%h b=%h acc=%h_%h: got we=%b st=%b %h_%h, exp %h", op, a, b,
               h, l, whilo, stallreq, hi_out, lo_out, exp);
    end
    step();
  endtask

  task automatic run_div(input aluop_t op, input logic [31:0] a, input logic [31:0] b, input bit scramble);
    logic [63:0] exp;
    int          stalls, exp_stalls;
    bit          done;
    aluop = op; reg1 = a; reg2 = b;
    exp        = model_div(a, b, op == EXE_DIV_OP);
    exp_stalls = (b == 32'd0) ? 2 : 33;
    stalls = 0;
    done   = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (!stallreq) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (whilo !== 1'b0) begin
          errors++;
          $display("FAIL div_we_during_stall: got we=%b at stall %0d, exp 0", whilo, stalls);
        end
        step();
        if (scramble) begin
          reg1 = $urandom;
          reg2 = $urandom;
        end
      end
    end
    checks++;
    if (!done || stalls != exp_stalls) begin
      errors++;
      $display("FAIL div_latency op=%h a=%h b=%h: got %0d stalls (done=%b), exp %0d", op, a, b,
               stalls, done, exp_stalls);
    end
    checks++;
    if (whilo !== 1'b1 || {hi_out, lo_out} !== exp) begin
      errors++;
      $display("FAIL div_result op=%h a=%h b=%h: got we=%b hi=%h lo=%h, exp hi=%h lo=%h", op, a, b,
               whilo, hi_out, lo_out, exp[63:32], exp[31:0]);
    end
    step();
  endtask

  task automatic test_reset();
    aluop = EXE_MULT_OP; reg1 = 32'h1234_5678; reg2 = 32'h9;
    #2;
    checks++;
    if (whilo !== 1'b0 || stallreq !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b st=%b hi=%h lo=%h, exp all 0", whilo, stallreq, hi_out, lo_out);
    end
    @(negedge clk);
    rst = 1'b1;
    aluop = EXE_NOP_OP;
    step();
    @(negedge clk);
    checks++;
    if (whilo !== 1'b0 || stallreq !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      errors++;
      $display("FAIL nop_outputs: got we=%b st=%b hi=%h lo=%h, exp all 0", whilo, stallreq, hi_out, lo_out);
    end
    step();
  endtask

  task automatic test_mul();
    run_mul(EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3);
    run_mul(EXE_MULTU_OP, 32'hFFFF_FFFE, 32'd3);
    run_mul(EXE_MULT_OP, 32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 8; i++) run_mul((i % 2) ? EXE_MULTU_OP : EXE_MULT_OP, $urandom, $urandom);
  endtask

  task automatic test_madd();
    run_madd(EXE_MADDU_OP, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd5);
    run_madd(EXE_MSUB_OP, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd5);
    run_madd(EXE_MADD_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: run_madd(EXE_MADD_OP, $urandom, $urandom, $urandom, $urandom);
        1: run_madd(EXE_MADDU_OP, $urandom, $urandom, $urandom, $urandom);
        2: run_madd(EXE_MSUB_OP, $urandom, $urandom, $urandom, $urandom);
        default: run_madd(EXE_MSUBU_OP, $urandom, $urandom, $urandom, $urandom);
      endcase
    end
  endtask

  task automatic test_div();
    run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_div(EXE_DIVU_OP, 32'd100, 32'd0, 1'b0);
    run_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1, 1'b1);
    for (int i = 0; i < 10; i++)
      run_div((i % 2) ? EXE_DIVU_OP : EXE_DIV_OP, $urandom, (i == 4) ? 32'd0 : 32'($urandom_range(1, 65535)) ^ (32'($urandom_range(0, 1)) << 31), 1'b1);
    aluop = EXE_NOP_OP;
    step();
  endtask

  task automatic test_annul();
    aluop = EXE_DIVU_OP; reg1 = 32'd100; reg2 = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (stallreq !== 1'b1) begin
        errors++;
        $display("FAIL annul_pre_stall cyc=%0d: got st=%b, exp 1", i, stallreq);
      end
      step();
    end
    annul = 1'b1;
    @(negedge clk);
    checks++;
    if (stallreq !== 1'b0 || whilo !== 1'b0) begin
      errors++;
      $display("FAIL annul_same_cycle: got we=%b st=%b, exp we=0 st=0", whilo, stallreq);
    end
    step();
    annul = 1'b0;
    run_div(EXE_DIVU_OP, 32'd100, 32'd7, 1'b0);
    run_div(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 1'b0);
    aluop = EXE_MADD_OP; reg1 = 32'd3; reg2 = 32'd4; annul = 1'b1;
    @(negedge clk);
    checks++;
    if (stallreq !== 1'b0 || whilo !== 1'b0) begin
      errors++;
      $display("FAIL annul_madd: got we=%b st=%b, exp we=0 st=0", whilo, stallreq);
    end
    step();
    annul = 1'b0;
    run_madd(EXE_MADD_OP, 32'd3, 32'd4, 32'd0, 32'd1);
  endtask

  task automatic test_back_to_back();
    run_mul(EXE_MULTU_OP, 32'd6, 32'd7);
    run_madd(EXE_MSUBU_OP, 32'd2, 32'd3, 32'd0, 32'd10);
    run_div(EXE_DIVU_OP, 32'd1000, 32'd3, 1'b0);
    run_div(EXE_DIV_OP, 32'hFFFF_FC18, 32'd3, 1'b0);
    run_madd(EXE_MADDU_OP, 32'd2, 32'd3, 32'd1, 32'd1);
    run_madd(EXE_MADDU_OP, 32'd5, 32'd5, 32'd0, 32'd0);
    run_mul(EXE_MULT_OP, 32'hFFFF_FFFF, 32'd5);
  endtask

  task automatic test_async_reset();
    aluop = EXE_DIVU_OP; reg1 = 32'd1000; reg2 = 32'd3;
    for (int i = 0; i < 6; i++) step();
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (whilo !== 1'b0 || stallreq !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      errors++;
      $display("FAIL async_rst_div: got we=%b st=%b hi=%h lo=%h, exp all 0", whilo, stallreq, hi_out, lo_out);
    end
    aluop = EXE_MULT_OP; reg1 = 32'd9; reg2 = 32'd9;
    #1;
    checks++;
    if (whilo !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      errors++;
      $display("FAIL async_rst_mul: got we=%b hi=%h lo=%h, exp all 0", whilo, hi_out, lo_out);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    step();
    run_mul(EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3);
    aluop = EXE_MADDU_OP; reg1 = 32'd8; reg2 = 32'd8; hi_in = '0; lo_in = '0;
    @(negedge clk);
    checks++;
    if (stallreq !== 1'b1) begin
      errors++;
      $display("FAIL async_rst_madd_c1: got st=%b, exp 1", stallreq);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (whilo !== 1'b0 || stallreq !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      errors++;
      $display("FAIL async_rst_madd: got we=%b st=%b hi=%h lo=%h, exp all 0", whilo, stallreq, hi_out, lo_out);
    end
    aluop = EXE_NOP_OP;
    step();
    #3;
    rst = 1'b1;
    step();
    run_madd(EXE_MADDU_OP, 32'd8, 32'd8, 32'd0, 32'd1);
    run_mul(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_madd();
    test_div();
    test_annul();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
